// File: rtl/airlock_sequencer_pkg.sv
// airlock_sequencer_pkg: state and transit codes shared by the airlock sequencer
package airlock_sequencer_pkg;
    typedef enum logic [2:0] {IDLE, PREP1, OPEN1, CLOSE1, PREP2, OPEN2, CLOSE2, FAULT} state_t;
    typedef enum logic {ARRIVE = 1'b0, DEPART = 1'b1} dir_t;
    function automatic logic side_inner(dir_t d, logic second);
        return (d == DEPART) ^ second;
    endfunction
endpackage

// File: rtl/airlock_sequencer_timer.sv
// airlock_sequencer_timer: per-state cycle counter with terminal-count compare
module airlock_sequencer_timer #(
    parameter int CW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          enable,
    input  logic [CW-1:0] term,
    output logic          done
);
    logic [CW-1:0] count;
    // Restart on every state change, otherwise count cycles spent in the state
    always_ff @(posedge clk)
        if (!reset || clear) count <= '0;
        else if (enable) count <= count + CW'(1);
    assign done = count == term;
endmodule

// File: rtl/airlock_sequencer.sv
// airlock_sequencer: arbitrates arrive/depart transits and sequences doors and pressure
module airlock_sequencer
    import airlock_sequencer_pkg::*;
#(
    parameter int PRESS_TIMEOUT = 32,
    parameter int DOOR_TIMEOUT  = 255,
    parameter int CW            = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic arriveReq,
    input  logic departReq,
    input  logic innerDoorState,
    input  logic outerDoorState,
    input  logic pressurized,
    output logic pressurizeSignal,
    output logic depressurizeSignal,
    output logic innerUnlock,
    output logic outerUnlock,
    output logic busy,
    output logic donePulse,
    output logic abortPulse,
    output logic fault
);
    state_t state, state_nxt;
    dir_t   dir, dir_nxt, last_served;
    logic   pend_arr, pend_dep, grant, inner_was, outer_was, timer_done;
    logic   inner_side, door_open, at_target, door_fault, in_prep;
    logic   nxt_inner, nxt_open, nxt_pulse;

    assign inner_side = side_inner(dir, state inside {PREP2, OPEN2, CLOSE2});
    assign door_open  = inner_side ? innerDoorState : outerDoorState;
    assign at_target  = pressurized == inner_side;
    assign in_prep    = state inside {PREP1, PREP2};
    assign door_fault = (innerDoorState & outerDoorState)
                      | (innerDoorState & ~(innerUnlock | inner_was))
                      | (outerDoorState & ~(outerUnlock | outer_was));
    assign nxt_inner  = side_inner(dir_nxt, state_nxt inside {PREP2, OPEN2, CLOSE2});
    assign nxt_open   = state_nxt inside {OPEN1, CLOSE1, OPEN2, CLOSE2};
    assign nxt_pulse  = (state_nxt inside {PREP1, PREP2}) && state_nxt != state && pressurized != nxt_inner;

    airlock_sequencer_timer #(.CW(CW)) u_timer (
        .clk    (clk),
        .reset  (reset),
        .clear  (state_nxt != state),
        .enable (busy),
        .term   (in_prep ? CW'(PRESS_TIMEOUT - 1) : CW'(DOOR_TIMEOUT - 1)),
        .done   (timer_done)
    );

    // Next state: door-safety violations override the normal transit sequence
    always_comb begin
        state_nxt = state;
        dir_nxt = dir;
        grant = 1'b0;
        if (state != FAULT && door_fault) state_nxt = FAULT;
        else
            case (state)
                IDLE: if (pend_arr | pend_dep) begin
                    grant = 1'b1;
                    dir_nxt = (pend_arr && (!pend_dep || last_served == DEPART)) ? ARRIVE : DEPART;
                    state_nxt = PREP1;
                end
                PREP1:   state_nxt = at_target ? OPEN1 : timer_done ? FAULT : PREP1;
                PREP2:   state_nxt = at_target ? OPEN2 : timer_done ? FAULT : PREP2;
                OPEN1:   state_nxt = door_open ? CLOSE1 : timer_done ? IDLE : OPEN1;
                OPEN2:   state_nxt = door_open ? CLOSE2 : timer_done ? IDLE : OPEN2;
                CLOSE1:  state_nxt = door_open ? CLOSE1 : PREP2;
                CLOSE2:  state_nxt = door_open ? CLOSE2 : IDLE;
                default: state_nxt = FAULT;
            endcase
    end

    // Transit bookkeeping: state, active direction, fairness and latched requests
    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= IDLE;
            dir <= ARRIVE;
            last_served <= DEPART;
            pend_arr <= 1'b0;
            pend_dep <= 1'b0;
        end else begin
            state <= state_nxt;
            dir <= dir_nxt;
            if (state == CLOSE2 && state_nxt == IDLE) last_served <= dir;
            pend_arr <= (grant && dir_nxt == ARRIVE) ? 1'b0 : pend_arr | arriveReq;
            pend_dep <= (grant && dir_nxt == DEPART) ? 1'b0 : pend_dep | departReq;
        end
    end

    // Registered outputs follow the state being entered so they line up with it
    always_ff @(posedge clk) begin
        if (!reset) begin
            pressurizeSignal <= 1'b1;
            depressurizeSignal <= 1'b1;
            innerUnlock <= 1'b0;
            outerUnlock <= 1'b0;
            inner_was <= 1'b0;
            outer_was <= 1'b0;
            busy <= 1'b0;
            donePulse <= 1'b0;
            abortPulse <= 1'b0;
            fault <= 1'b0;
        end else begin
            pressurizeSignal <= ~(nxt_pulse & nxt_inner);
            depressurizeSignal <= ~(nxt_pulse & ~nxt_inner);
            innerUnlock <= nxt_open & nxt_inner;
            outerUnlock <= nxt_open & ~nxt_inner;
            inner_was <= innerUnlock;
            outer_was <= outerUnlock;
            busy <= state_nxt != IDLE;
            donePulse <= state == CLOSE2 && state_nxt == IDLE;
            abortPulse <= (state == OPEN1 || state == OPEN2) && state_nxt == IDLE;
            fault <= state_nxt == FAULT;
        end
    end
endmodule

// File: tb/tb_airlock_sequencer.sv
// tb_airlock_sequencer: directed and randomized checks against a transit-level reference model
`timescale 1ns/1ps
module tb_airlock_sequencer;
    localparam int PT = 32;
    localparam int DT = 255;

    logic clk = 1'b0, reset = 1'b0, arriveReq = 1'b0, departReq = 1'b0;
    logic innerDoorState = 1'b0, outerDoorState = 1'b0, pressurized = 1'b0;
    logic pressurizeSignal, depressurizeSignal, innerUnlock, outerUnlock, busy, donePulse, abortPulse, fault;

    int vectors = 0, miscompares = 0;

    // Reference model: a transit is two phases (side = dir ^ phase, 1 = inner),
    // each with steps 0 = reach pressure, 1 = wait for door open, 2 = wait for close.
    bit mv, m_busy, m_fault, m_dir, m_phase, m_pa, m_pd, m_last, p_iu, p_ou;
    bit e_pz = 1'b1, e_dz = 1'b1, e_done, e_abort;
    int m_step, m_age;

    bit pr_goal;
    int pr_cnt;

    airlock_sequencer #(.PRESS_TIMEOUT(PT), .DOOR_TIMEOUT(DT), .CW(8)) dut (
        .clk                (clk),
        .reset              (reset),
        .arriveReq          (arriveReq),
        .departReq          (departReq),
        .innerDoorState     (innerDoorState),
        .outerDoorState     (outerDoorState),
        .pressurized        (pressurized),
        .pressurizeSignal   (pressurizeSignal),
        .depressurizeSignal (depressurizeSignal),
        .innerUnlock        (innerUnlock),
        .outerUnlock        (outerUnlock),
        .busy               (busy),
        .donePulse          (donePulse),
        .abortPulse         (abortPulse),
        .fault              (fault)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic act, input logic exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %b, expected %b", name, $time, act, exp);
        end
    endtask

    function automatic bit exp_iu();
        return m_busy && !m_fault && m_step != 0 && (m_dir ^ m_phase);
    endfunction

    function automatic bit exp_ou();
        return m_busy && !m_fault && m_step != 0 && !(m_dir ^ m_phase);
    endfunction

    task automatic pulse_for(input bit tgt);
        if (pressurized != tgt) begin
            if (tgt) e_pz = 1'b0;
            else e_dz = 1'b0;
        end
    endtask

    task automatic model_step();
        bit ci, co, side, door, gi, gd, viol;
        e_pz = 1'b1;
        e_dz = 1'b1;
        e_done = 1'b0;
        e_abort = 1'b0;
        if (!reset) begin
            mv = 1'b1; m_busy = 1'b0; m_fault = 1'b0; m_pa = 1'b0; m_pd = 1'b0; m_last = 1'b1;
            m_step = 0; m_phase = 1'b0; m_age = 0; p_iu = 1'b0; p_ou = 1'b0;
            return;
        end
        ci = exp_iu();
        co = exp_ou();
        side = m_dir ^ m_phase;
        door = side ? innerDoorState : outerDoorState;
        viol = (innerDoorState && outerDoorState) || (innerDoorState && !ci && !p_iu) || (outerDoorState && !co && !p_ou);
        gi = 1'b0;
        gd = 1'b0;
        if (!m_fault) begin
            if (viol) m_fault = 1'b1;
            else if (!m_busy) begin
                if (m_pa || m_pd) begin
                    m_dir = !(m_pa && (!m_pd || m_last));
                    gi = !m_dir;
                    gd = m_dir;
                    m_busy = 1'b1; m_phase = 1'b0; m_step = 0; m_age = 0;
                    pulse_for(m_dir);
                end
            end else if (m_step == 0) begin
                if (pressurized == side) begin m_step = 1; m_age = 0; end
                else if (m_age == PT - 1) m_fault = 1'b1;
                else m_age++;
            end else if (m_step == 1) begin
                if (door) begin m_step = 2; m_age = 0; end
                else if (m_age == DT - 1) begin m_busy = 1'b0; e_abort = 1'b1; end
                else m_age++;
            end else if (!door) begin
                if (!m_phase) begin
                    m_phase = 1'b1; m_step = 0; m_age = 0;
                    pulse_for(!m_dir);
                end else begin
                    m_busy = 1'b0; e_done = 1'b1; m_last = m_dir;
                end
            end
        end
        m_pa = !gi && (m_pa || arriveReq);
        m_pd = !gd && (m_pd || departReq);
        p_iu = ci;
        p_ou = co;
    endtask

    task automatic compare();
        if (!mv) return;
        chk("innerUnlock", innerUnlock, exp_iu());
        chk("outerUnlock", outerUnlock, exp_ou());
        chk("pressurizeSignal", pressurizeSignal, e_pz);
        chk("depressurizeSignal", depressurizeSignal, e_dz);
        chk("busy", busy, m_busy | m_fault);
        chk("donePulse", donePulse, e_done);
        chk("abortPulse", abortPulse, e_abort);
        chk("fault", fault, m_fault);
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        @(negedge clk);
        compare();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        arriveReq = 1'b0;
        departReq = 1'b0;
        innerDoorState = 1'b0;
        outerDoorState = 1'b0;
        pr_cnt = 0;
        tick();
        reset = 1'b1;
    endtask

    // Environment: pressurizer reacting to pulses, doors used only while unlocked
    task automatic env_drive(input bit wild);
        if (!pressurizeSignal || !depressurizeSignal) begin
            pr_goal = !pressurizeSignal;
            pr_cnt = (wild && $urandom_range(0, 29) == 0) ? 40 : $urandom_range(1, 8);
        end
        if (pr_cnt > 0) begin
            pr_cnt--;
            if (pr_cnt == 0) pressurized = pr_goal;
        end
        innerDoorState = innerUnlock ? (($urandom_range(0, 2) == 0) ? !innerDoorState : innerDoorState) : 1'b0;
        outerDoorState = outerUnlock ? (($urandom_range(0, 2) == 0) ? !outerDoorState : outerDoorState) : 1'b0;
        if (wild) begin
            arriveReq = $urandom_range(0, 7) == 0;
            departReq = $urandom_range(0, 7) == 0;
            if ($urandom_range(0, 399) == 0) innerDoorState = 1'b1;
            if ($urandom_range(0, 399) == 0) outerDoorState = 1'b1;
        end
    endtask

    task automatic run_until_done(input int bound, input string name);
        int n = 0;
        while (donePulse !== 1'b1 && n < bound) begin
            env_drive(1'b0);
            tick();
            n++;
        end
        chk(name, donePulse, 1'b1);
    endtask

    initial begin
        do_reset();
        tick();
        chk("rst_busy", busy, 1'b0);
        chk("rst_pz", pressurizeSignal, 1'b1);
        chk("rst_fault", fault, 1'b0);

        // Arrive at vacuum: no first pulse, pressurize once after the outer door closes
        pressurized = 1'b0;
        arriveReq = 1'b1;
        tick();
        arriveReq = 1'b0;
        tick();
        chk("t1_prep_ou", outerUnlock, 1'b0);
        chk("t1_prep_dz", depressurizeSignal, 1'b1);
        tick();
        chk("t1_open_ou", outerUnlock, 1'b1);
        outerDoorState = 1'b1;
        tick();
        chk("t1_close_ou", outerUnlock, 1'b1);
        outerDoorState = 1'b0;
        tick();
        chk("t1_relock", outerUnlock, 1'b0);
        chk("t1_pz_low", pressurizeSignal, 1'b0);
        chk("t1_dz_high", depressurizeSignal, 1'b1);
        tick();
        chk("t1_pz_once", pressurizeSignal, 1'b1);
        pressurized = 1'b1;
        tick();
        chk("t1_iu", innerUnlock, 1'b1);
        innerDoorState = 1'b1;
        tick();
        innerDoorState = 1'b0;
        tick();
        chk("t1_done", donePulse, 1'b1);
        chk("t1_idle", busy, 1'b0);
        tick();
        chk("t1_done_once", donePulse, 1'b0);

        // Simultaneous requests: arrive first, depart after one IDLE cycle
        do_reset();
        pressurized = 1'b0;
        arriveReq = 1'b1;
        departReq = 1'b1;
        tick();
        arriveReq = 1'b0;
        departReq = 1'b0;
        tick();
        tick();
        chk("t2_arrive_ou", outerUnlock, 1'b1);
        chk("t2_arrive_iu", innerUnlock, 1'b0);
        run_until_done(200, "t2_arrive_done");
        chk("t2_gap_idle", busy, 1'b0);
        tick();
        chk("t2_depart_busy", busy, 1'b1);
        run_until_done(200, "t2_depart_done");

        // Pressure never reached: fault on the 33rd cycle of PREP1
        do_reset();
        pressurized = 1'b0;
        departReq = 1'b1;
        tick();
        departReq = 1'b0;
        tick();
        chk("t3_pulse", pressurizeSignal, 1'b0);
        for (int c = 2; c <= 32; c++) tick();
        chk("t3_c32", fault, 1'b0);
        tick();
        chk("t3_c33", fault, 1'b1);
        chk("t3_iu", innerUnlock, 1'b0);
        chk("t3_pz", pressurizeSignal, 1'b1);
        pressurized = 1'b1;
        for (int c = 0; c < 3; c++) tick();
        chk("t3_sticky", fault, 1'b1);

        // Inner door opened while locked during PREP1 of an arrive
        do_reset();
        pressurized = 1'b1;
        arriveReq = 1'b1;
        tick();
        arriveReq = 1'b0;
        tick();
        chk("t4_dz", depressurizeSignal, 1'b0);
        innerDoorState = 1'b1;
        tick();
        chk("t4_fault", fault, 1'b1);
        innerDoorState = 1'b0;

        // Outer door never opened: abort after 255 cycles
        do_reset();
        pressurized = 1'b0;
        arriveReq = 1'b1;
        tick();
        arriveReq = 1'b0;
        tick();
        tick();
        chk("t5_c1", outerUnlock, 1'b1);
        for (int c = 0; c < 254; c++) tick();
        chk("t5_c255", outerUnlock, 1'b1);
        tick();
        chk("t5_relock", outerUnlock, 1'b0);
        chk("t5_abort", abortPulse, 1'b1);
        chk("t5_idle", busy, 1'b0);
        tick();
        chk("t5_abort_once", abortPulse, 1'b0);

        // Reset during CLOSE2 drops the transit and the pending depart
        do_reset();
        pressurized = 1'b0;
        arriveReq = 1'b1;
        tick();
        arriveReq = 1'b0;
        tick();
        tick();
        outerDoorState = 1'b1;
        departReq = 1'b1;
        tick();
        outerDoorState = 1'b0;
        departReq = 1'b0;
        tick();
        pressurized = 1'b1;
        tick();
        innerDoorState = 1'b1;
        tick();
        chk("t6_close2_iu", innerUnlock, 1'b1);
        reset = 1'b0;
        innerDoorState = 1'b0;
        tick();
        chk("t6_rst_busy", busy, 1'b0);
        chk("t6_rst_iu", innerUnlock, 1'b0);
        reset = 1'b1;
        tick();
        tick();
        chk("t6_pend_cleared", busy, 1'b0);
        arriveReq = 1'b1;
        tick();
        arriveReq = 1'b0;
        tick();
        chk("t6_new_busy", busy, 1'b1);
        run_until_done(200, "t6_new_done");

        // Randomized traffic with occasional violations, stuck pressure and resets
        do_reset();
        for (int i = 0; i < 4000; i++) begin
            if ((fault && $urandom_range(0, 3) == 0) || $urandom_range(0, 599) == 0) begin
                reset = 1'b0;
                innerDoorState = 1'b0;
                outerDoorState = 1'b0;
                tick();
                reset = 1'b1;
            end else begin
                env_drive(1'b1);
                tick();
            end
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
